// File: rtl/lockin_ui_pkg.sv
// Shared LockIn UI constants (50 MHz board clock) and the counter-width helper
// used by the pulse stretcher and by button_edge_detector users.
package lockin_ui_pkg;

    localparam int unsigned CLK_HZ           = 50_000_000;
    localparam int unsigned HOLD_CYCLES_DEF  = 5_000_000;   // 100 ms
    localparam int unsigned BLINK_HALF_DEF   = 1_250_000;   // 25 ms half-period

    // Bits needed to hold values 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/stretch_channel.sv
// One stretcher lane: hold down-counter, trigger acceptance and the
// next-state active flag that the top level registers onto the LED.
module stretch_channel
    import lockin_ui_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter bit          RETRIGGER   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse,
    output logic active_nxt
);

    localparam int unsigned CW      = cnt_width(HOLD_CYCLES);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          idle;

    assign idle = (cnt_q == '0);

    // Without retrigger a pulse is only taken from idle, so even a pulse at
    // cnt==1 is dropped and the LED shows a gap before the next hold.
    always_comb begin
        cnt_d = cnt_q;
        if (pulse && (idle || RETRIGGER)) begin
            cnt_d = HOLD_LD;
        end else if (!idle) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign active_nxt = (cnt_d != '0);

endmodule

// File: rtl/led_pulse_stretcher.sv
// Stretches per-channel event pulses into fixed-length LED drive.
// Optional blink of lit LEDs when LED_BLINK_EN is defined.
module led_pulse_stretcher
    import lockin_ui_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter bit          RETRIGGER   = 1'b1,
    parameter int unsigned BLINK_HALF  = BLINK_HALF_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] pulse_in,
    output logic [NUM_CH-1:0] led_out,
    output logic              any_active
);

    logic [NUM_CH-1:0] act_nxt;
    logic [NUM_CH-1:0] blink_mask;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        stretch_channel #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .RETRIGGER   (RETRIGGER)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .pulse      (pulse_in[g]),
            .active_nxt (act_nxt[g])
        );
    end

`ifdef LED_BLINK_EN
    localparam int unsigned BW = cnt_width(BLINK_HALF);
    localparam logic [BW-1:0] DIV_LAST = BW'(BLINK_HALF - 1);

    logic [BW-1:0] div_q;
    logic [BW-1:0] div_d;
    logic          ph_q;
    logic          ph_d;

    always_comb begin
        div_d = div_q + BW'(1);
        ph_d  = ph_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            ph_d  = ~ph_q;
        end
    end

    // Phase restarts lit so a press right after reset is visible at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            ph_q  <= 1'b1;
        end else begin
            div_q <= div_d;
            ph_q  <= ph_d;
        end
    end

    assign blink_mask = {NUM_CH{ph_d}};
`else
    assign blink_mask = '1;
`endif

    // Registered from next-state flags so led_out and any_active line up.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_out    <= '0;
            any_active <= 1'b0;
        end else begin
            led_out    <= act_nxt & blink_mask;
            any_active <= |act_nxt;
        end
    end

endmodule
